// File: rtl/fetch_decode_stage.sv
// rtl/fetch_decode_stage.sv - PC register, IF/ID pipeline register and field decode.
// Optional stall/flush performance counters are enabled by FETCH_PERF_CNT_EN.
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic [31:0] PCF,
  input  logic [31:0] InstrF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [6:0]  opD,
  output logic [2:0]  funct3D,
  output logic        funct7b5D,
  output logic [4:0]  Rs1D,
  output logic [4:0]  Rs2D,
`ifdef FETCH_PERF_CNT_EN
  output logic [4:0]  RdD,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt
`else
  output logic [4:0]  RdD
`endif
);

  logic [31:0] pcf_q, pcf_d;
  logic [31:0] pc_plus4_f, pc_next;
  logic [31:0] instr_d_q, instr_d_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pcplus4d_q, pcplus4d_d;
  logic        valid_d_q, valid_d_d;
  logic        unused_tgt_lsbs;

  // Targets are word aligned; the low bits are dropped on purpose.
  assign unused_tgt_lsbs = ^PCTargetE[1:0];

  always_comb begin
    pc_plus4_f = pcf_q + 32'd4;
    pc_next    = PCSrcE ? {PCTargetE[31:2], 2'b00} : pc_plus4_f;
    pcf_d      = pcf_q;
    if (PCSrcE || !StallF) begin
      pcf_d = pc_next;
    end

    instr_d_d  = instr_d_q;
    pcd_d      = pcd_q;
    pcplus4d_d = pcplus4d_q;
    valid_d_d  = valid_d_q;
    if (FlushD) begin
      instr_d_d  = NOP_INSTR;
      pcd_d      = 32'd0;
      pcplus4d_d = 32'd0;
      valid_d_d  = 1'b0;
    end else if (!StallD) begin
      instr_d_d  = InstrF;
      pcd_d      = pcf_q;
      pcplus4d_d = pc_plus4_f;
      valid_d_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcf_q      <= RESET_PC;
      instr_d_q  <= NOP_INSTR;
      pcd_q      <= 32'd0;
      pcplus4d_q <= 32'd0;
      valid_d_q  <= 1'b0;
    end else begin
      pcf_q      <= pcf_d;
      instr_d_q  <= instr_d_d;
      pcd_q      <= pcd_d;
      pcplus4d_q <= pcplus4d_d;
      valid_d_q  <= valid_d_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallD && !FlushD && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (FlushD && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

  assign PCF       = pcf_q;
  assign InstrD    = instr_d_q;
  assign PCD       = pcd_q;
  assign PCPlus4D  = pcplus4d_q;
  assign ValidD    = valid_d_q;
  assign opD       = instr_d_q[6:0];
  assign RdD       = instr_d_q[11:7];
  assign funct3D   = instr_d_q[14:12];
  assign Rs1D      = instr_d_q[19:15];
  assign Rs2D      = instr_d_q[24:20];
  assign funct7b5D = instr_d_q[30];

endmodule

// File: doc/fetch_decode_stage.md
FETCH_DECODE_STAGE -- requirements
Module: fetch_decode_stage

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PCF value loaded on reset.
REQ-002 SHALL have parameter: NOP_INSTR, 32'h0000_0013 (addi x0,x0,0), instruction injected into Decode on reset or flush.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: StallF  input  1  hold PCF.
REQ-006 SHALL have port: StallD  input  1  hold IF/ID register.
REQ-007 SHALL have port: FlushD  input  1  replace IF/ID contents with bubble.
REQ-008 SHALL have port: PCSrcE  input  1  redirect request from Execute, taken branch or jump.
REQ-009 SHALL have port: PCTargetE  input  32  redirect target.
REQ-010 SHALL have port: PCF  output  32  instruction memory address.
REQ-011 SHALL have port: InstrF  input  32  instruction memory read data, combinational in the same cycle as PCF.
REQ-012 SHALL have port: InstrD  output  32  registered instruction.
REQ-013 SHALL have port: PCD, PCPlus4D  output  32 each  registered PC and PC+4 of InstrD.
REQ-014 SHALL have port: ValidD  output  1  InstrD came from a real fetch, not a bubble.
REQ-015 SHALL have port: opD  output  7, funct3D  output  3, funct7b5D  output  1; feed the control unit.
REQ-016 SHALL have port: Rs1D, Rs2D, RdD  output  5 each  register fields, feed register file and hazard unit.

Function
REQ-017 SHALL compute PCPlus4F = PCF + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
REQ-018 SHALL select PCNext = PCSrcE ? {PCTargetE[31:2],2'b00} : PCPlus4F; target bits [1:0] ignored.
REQ-019 SHALL load PCF <= PCNext each edge unless StallF=1 and PCSrcE=0; PCSrcE=1 overrides StallF.
REQ-020 SHALL update IF/ID with priority FlushD > StallD > load. Flush: InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0. Stall: hold all. Load: InstrD=InstrF, PCD=PCF, PCPlus4D=PCPlus4F, ValidD=1.
REQ-021 SHALL present the instruction at PCF in cycle n on InstrD in cycle n+1 (1-cycle latency) absent stall or flush.
REQ-022 SHALL decode fields combinationally from InstrD: opD=[6:0], RdD=[11:7], funct3D=[14:12], Rs1D=[19:15], Rs2D=[24:20], funct7b5D=[30].
REQ-023 SHALL not drop an instruction during StallF=StallD=1: the same PCF is refetched and InstrD is held until the stall releases.
REQ-024 SHALL treat StallD with FlushD as a flush.

Reset
REQ-025 SHALL on reset=1 at an edge set PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, and all counters to 0.
REQ-026 SHALL give reset priority over PCSrcE, StallF, StallD and FlushD.
REQ-027 SHALL restart cleanly when reset is asserted mid-stall or mid-redirect: the first fetch after release is at RESET_PC.

Configuration
REQ-028 SHALL add outputs StallCnt (32) and FlushCnt (32) when macro FETCH_PERF_CNT_EN is defined.
REQ-029 SHALL increment StallCnt on each edge with StallD=1 and FlushD=0; SHALL increment FlushCnt on each edge with FlushD=1; both saturate at 32'hFFFF_FFFF; reset clears both.
REQ-030 SHALL omit the counters and both ports entirely when FETCH_PERF_CNT_EN is undefined; all other behaviour stays identical.

Verification
REQ-031 Sequential fetch: reset, then 3 free cycles with InstrF=mem[PCF] -> PCF 0,4,8,C; InstrD = mem[0] in cycle 1, ValidD=1.
REQ-032 Redirect: PCSrcE=1, PCTargetE=32'h0000_0102, FlushD=1 for 1 cycle -> next PCF=32'h100; InstrD=32'h13, ValidD=0, PCD=0.
REQ-033 Load-use stall: StallF=StallD=1 for 2 cycles at PCF=8 -> PCF holds 8 and InstrD/PCD hold; counter build gives StallCnt=2.
REQ-034 Priority: StallF=1 with PCSrcE=1, target 32'h40 -> PCF=32'h40; StallD=1 with FlushD=1 -> bubble, FlushCnt+1, StallCnt unchanged.
REQ-035 Wrap: PCF=32'hFFFF_FFFC, no stall -> PCF=0, PCPlus4D=0.
REQ-036 Reset mid-stall: StallF=1, reset=1 -> PCF=RESET_PC, InstrD=32'h13, counters 0.
